// File: rtl/score_event_serializer_pkg.sv
// score_event_serializer_pkg: shared defaults, source/state encodings and round-robin helper
package score_event_serializer_pkg;
  localparam int SCORE_PENDING_WIDTH = 4;
  localparam int SCORE_BOSS_WEIGHT = 5;
  localparam int SCORE_GAP_CYCLES = 1;
  typedef enum logic [1:0] {SRC_MONSTER = 2'd0, SRC_BOSS = 2'd1, SRC_ASTEROID = 2'd2} score_src;
  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GAP} score_state;
  function automatic score_src next_src(score_src s);
    return s == SRC_ASTEROID ? SRC_MONSTER : score_src'(s + 2'd1);
  endfunction
endpackage

// File: rtl/score_event_serializer_if.sv
// score_event_serializer_if: kill-event inputs and serialized score outputs
interface score_event_serializer_if;
  logic monster_died_pulse_in;
  logic boss_died_pulse_in;
  logic asteroid_exploded_pulse_in;
  logic game_over;
  logic monster_died_pulse;
  logic boss_died_pulse;
  logic asteroid_exploded_pulse;
  logic busy;
  logic overflow;
  modport master(
    output monster_died_pulse_in, boss_died_pulse_in, asteroid_exploded_pulse_in, game_over,
    input monster_died_pulse, boss_died_pulse, asteroid_exploded_pulse, busy, overflow
  );
  modport slave(
    input monster_died_pulse_in, boss_died_pulse_in, asteroid_exploded_pulse_in, game_over,
    output monster_died_pulse, boss_died_pulse, asteroid_exploded_pulse, busy, overflow
  );
endinterface

// File: rtl/score_event_serializer_sat_pending_counter.sv
// sat_pending_counter: saturating pending counter with combined add/subtract and clip strobe
module sat_pending_counter #(
  parameter int PENDING_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [PENDING_WIDTH-1:0] inc,
  input  logic                     dec,
  output logic [PENDING_WIDTH-1:0] cnt,
  output logic                     ovf
);
  localparam logic [PENDING_WIDTH:0] MAX = {1'b0, {PENDING_WIDTH{1'b1}}};
  logic [PENDING_WIDTH:0] ideal;
  // dec is only asserted when cnt >= 1, so the extra bit only ever holds a carry
  assign ideal = {1'b0, cnt} + {1'b0, inc} - (PENDING_WIDTH + 1)'(dec);
  assign ovf = !clear && ideal > MAX;
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else cnt <= ovf ? MAX[PENDING_WIDTH-1:0] : ideal[PENDING_WIDTH-1:0];
endmodule

// File: rtl/score_event_serializer.sv
// score_event_serializer: buffers kill events and re-emits them as spaced one-hot pulses
module score_event_serializer
  import score_event_serializer_pkg::*;
#(
  parameter int PENDING_WIDTH = SCORE_PENDING_WIDTH,
  parameter int BOSS_WEIGHT = SCORE_BOSS_WEIGHT,
  parameter int GAP_CYCLES = SCORE_GAP_CYCLES
) (
  input logic clk,
  input logic reset,
  score_event_serializer_if.slave bus
);
  localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  score_state state, state_next;
  score_src ptr, ptr_next, grant, c1, c2;
  logic [PENDING_WIDTH-1:0] cnt [3];
  logic [PENDING_WIDTH-1:0] inc [3];
  logic [2:0] nz, ovf, grant_oh, pulse, pulse_next, gap_cnt, gap_next;
  logic take, overflow_q;
  assign inc[0] = PENDING_WIDTH'(bus.monster_died_pulse_in);
  assign inc[1] = bus.boss_died_pulse_in ? PENDING_WIDTH'(BOSS_WEIGHT) : '0;
  assign inc[2] = PENDING_WIDTH'(bus.asteroid_exploded_pulse_in);
  for (genvar i = 0; i < 3; i++) begin : g_cnt
    sat_pending_counter #(.PENDING_WIDTH(PENDING_WIDTH)) u_cnt (
      .clk(clk), .reset(reset), .clear(bus.game_over), .inc(inc[i]),
      .dec(grant_oh[i]), .cnt(cnt[i]), .ovf(ovf[i])
    );
    assign nz[i] = |cnt[i];
  end
  // round-robin: first nonzero source starting at the pointer
  assign c1 = next_src(ptr);
  assign c2 = next_src(c1);
  assign grant = nz[ptr] ? ptr : nz[c1] ? c1 : c2;
  assign take = state == ST_IDLE && |nz && !bus.game_over;
  assign grant_oh = take ? 3'b001 << grant : 3'b000;
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_IDLE;
      ptr <= SRC_MONSTER;
      pulse <= '0;
      gap_cnt <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_next;
      ptr <= ptr_next;
      pulse <= pulse_next;
      gap_cnt <= gap_next;
      overflow_q <= overflow_q | |ovf;
    end
  always_comb
    state_next = bus.game_over ? ST_IDLE :
                 state == ST_IDLE ? (take ? ST_EMIT : ST_IDLE) :
                 state == ST_EMIT ? (GAP_CYCLES > 0 ? ST_GAP : ST_IDLE) :
                 gap_cnt == GAP_LAST ? ST_IDLE : ST_GAP;
  always_comb begin
    pulse_next = grant_oh;
    gap_next = state == ST_GAP && !bus.game_over ? gap_cnt + 3'd1 : 3'd0;
    ptr_next = bus.game_over ? SRC_MONSTER : take ? next_src(grant) : ptr;
  end
  assign bus.monster_died_pulse = pulse[0];
  assign bus.boss_died_pulse = pulse[1];
  assign bus.asteroid_exploded_pulse = pulse[2];
  assign bus.busy = state != ST_IDLE || |nz;
  assign bus.overflow = overflow_q;
endmodule

// File: doc/score_event_serializer.md
Name: score_event_serializer

Overview:
- Sits directly upstream of the score block and drives its monster/boss/asteroid event inputs.
- Accepts kill events from the game logic, which may be simultaneous or back-to-back, and buffers them in per-source pending counters.
- Re-emits them as at most one one-hot pulse per slot, with guaranteed idle gaps between slots, so that no credit is lost to coincident pulses.
- Boss kills are weighted: one boss event becomes BOSS_WEIGHT boss pulses.

Parameters:
- PENDING_WIDTH, 4: width of each per-source pending counter; counters saturate at 2^PENDING_WIDTH-1.
- BOSS_WEIGHT, 5: pulses queued per boss_died_pulse_in; must be 1..2^PENDING_WIDTH-1.
- GAP_CYCLES, 1: idle cycles forced after every emitted pulse; range 0..7.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- monster_died_pulse_in  in  1  one-cycle monster kill event
- boss_died_pulse_in  in  1  one-cycle boss kill event
- asteroid_exploded_pulse_in  in  1  one-cycle asteroid destruction event
- game_over  in  1  level; flushes and blocks the block while high
- monster_died_pulse  out  1  serialized pulse to score
- boss_died_pulse  out  1  serialized pulse to score
- asteroid_exploded_pulse  out  1  serialized pulse to score
- busy  out  1  high while any counter is nonzero or the FSM is not IDLE
- overflow  out  1  sticky; set when an increment is clipped by saturation

Behaviour:
- Reset (synchronous, reset=1 at the edge): all counters 0, all three pulse outputs 0, busy 0, overflow 0, FSM IDLE, round-robin pointer = monster.
- Counters: cnt_m, cnt_b, cnt_a, each PENDING_WIDTH bits, unsigned.
  - Each cycle: cnt_x_next = sat(cnt_x + inc_x - dec_x).
  - inc_m = monster_in; inc_a = asteroid_in; inc_b = BOSS_WEIGHT when boss_in is high.
  - dec_x = 1 when the FSM grants source x this cycle.
  - Increment and decrement in the same cycle net out; the result is never negative, since a grant requires cnt_x >= 1.
  - Saturation clips at max; overflow is set at that edge if the ideal result exceeded max.
- FSM states: IDLE, EMIT, GAP.
  - IDLE: if any counter is nonzero, grant one source round-robin. Order is monster -> boss -> asteroid, starting at the pointer. At that edge: set the granted output register to 1, decrement the granted counter, move the pointer to the source after the grant, go to EMIT.
  - EMIT: exactly one cycle with the granted output high; the others are 0. Next state is GAP if GAP_CYCLES>0, else IDLE. All outputs clear at the exit edge.
  - GAP: count GAP_CYCLES cycles with all outputs 0, then go to IDLE.
- Outputs are registered and at most one is high per cycle.
  - Latency: an input pulse in cycle t updates the counter at the end of t. With the FSM idle, the output pulse is high in cycle t+2.
  - Back-to-back throughput: one pulse every 1+GAP_CYCLES cycles, plus one IDLE decision cycle.
- game_over=1 (synchronous, checked before the counter update):
  - Counters cleared, outputs 0, FSM to IDLE, pointer to monster.
  - Input pulses in the same cycle are discarded; overflow is held.
  - The block stays inert while game_over is high.
- reset asserted mid-EMIT or mid-GAP: the output drops at that edge and the state returns to reset values.
- busy = (FSM != IDLE) | (cnt_m|cnt_b|cnt_a != 0).

Decomposition:
- Shared package parameters.sv gains:
  - SCORE_PENDING_WIDTH, SCORE_BOSS_WEIGHT, SCORE_GAP_CYCLES as defaults.
  - A 2-bit typedef score_src (SRC_MONSTER=0, SRC_BOSS=1, SRC_ASTEROID=2) used for the pointer and the grant.
- One natural sub-module: sat_pending_counter (PENDING_WIDTH, increment value, decrement, clear, overflow strobe), instantiated three times. Arbiter and FSM stay in the top.

Test Plan:
- Single monster_in at cycle 10, GAP_CYCLES=1 -> monster_died_pulse high only in cycle 12; busy is 0 from cycle 14; other outputs stay 0.
- monster_in, boss_in, asteroid_in all high in cycle 5 (BOSS_WEIGHT=5) -> 7 pulses total, one-hot, interleaved round-robin M,B,A,B,B,B,B. Pulses are spaced 3 cycles apart with GAP_CYCLES=1.
- 16 monster_in pulses on consecutive cycles, PENDING_WIDTH=4, no drain in between -> at most 15 buffered pending plus those drained, overflow goes 1 and stays 1; total emitted count equals 16 minus the clipped count computed by the model.
- monster_in at the same cycle the FSM grants monster with cnt_m=1 -> cnt_m stays 1 and a second pulse follows; no loss and no double count.
- Three events pending, game_over raised during EMIT -> the output drops next edge, no further pulses while high, input pulses ignored, busy=0; after game_over falls the counters start from 0.
- reset=1 for one cycle during GAP with cnt_b=3 -> all outputs 0, busy 0, overflow 0 next cycle; no pulses afterwards without new inputs.
